// File: rtl/spi_packet_master.sv
// SPI Mode-0 master that reads the 16-byte sensor packet, checks the header and unpacks the fields.
// Ports: clk/rst, done/sdi from the slave, sck/sdo/load to it, decoded fields, pulses and counters.
module spi_packet_master #(
  parameter int          CLK_DIV     = 4,
  parameter logic [7:0]  HEADER_BYTE = 8'hAA,
  parameter int          LOAD_CYCLES = 4,
  parameter int          CLR_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done,
  input  logic               sdi,
  output logic               sck,
  output logic               sdo,
  output logic               load,
  output logic               busy,
  output logic               pkt_valid,
  output logic               hdr_err,
  output logic               timeout_err,
  output logic signed [15:0] quat_w,
  output logic signed [15:0] quat_x,
  output logic signed [15:0] quat_y,
  output logic signed [15:0] quat_z,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               quat_valid,
  output logic               gyro_valid,
  output logic [15:0]        pkt_count,
  output logic [7:0]         err_count
);

  localparam int M1   = (CLK_DIV > LOAD_CYCLES) ? CLK_DIV : LOAD_CYCLES;
  localparam int CMAX = (M1 > CLR_TIMEOUT) ? M1 : CLR_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LD_END  = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] TO_END  = CW'(CLR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SHIFT,
    S_CHECK,
    S_ACK,
    S_WAIT_CLR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sck_q, sck_d;
  logic [6:0]      bit_q, bit_d;
  logic            shift_en;
  logic            word_done;
  logic            to_hit;
  logic            done_s1, done_sync;
  logic            hdr_ok;
  logic [1:0]      err_add;
  logic [8:0]      err_sum;

  // Only the first 127 bits are stored; the 128th is taken straight
  // from sdi on the final edge so the fields load in that same edge.
  logic [126:0]    shreg_q;

  logic            pv_q, he_q, to_q;
  logic [15:0]     f_w, f_x, f_y, f_z;
  logic [15:0]     f_gx, f_gy, f_gz;
  logic            qv_q, gv_q;
  logic [15:0]     pc_q;
  logic [7:0]      err_q;

  assign hdr_ok = (shreg_q[126:119] == HEADER_BYTE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    sck_d     = sck_q;
    bit_d     = bit_q;
    shift_en  = 1'b0;
    word_done = 1'b0;
    to_hit    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        sck_d = 1'b0;
        bit_d = '0;
        if (done_sync) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == DIV_END) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_END) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d    = 1'b0;
            shift_en = 1'b1;
            bit_d    = bit_q + 7'd1;
            if (bit_q == 7'd127) begin
              word_done = 1'b1;
              state_d   = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        cnt_d   = '0;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (cnt_q == LD_END) begin
          cnt_d   = '0;
          state_d = S_WAIT_CLR;
        end
      end
      S_WAIT_CLR: begin
        if (!done_sync) begin
          state_d = S_IDLE;
        end else if (cnt_q == TO_END) begin
          to_hit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sck_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sck_q     <= 1'b0;
      bit_q     <= '0;
      done_s1   <= 1'b0;
      done_sync <= 1'b0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sck_q     <= sck_d;
      bit_q     <= bit_d;
      done_s1   <= done;
      done_sync <= done_s1;
      if (shift_en) shreg_q <= {shreg_q[125:0], sdi};
    end
  end

  assign err_add = {1'b0, word_done & ~hdr_ok} + {1'b0, to_hit};
  assign err_sum = {1'b0, err_q} + {7'd0, err_add};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q  <= 1'b0;
      he_q  <= 1'b0;
      to_q  <= 1'b0;
      f_w   <= '0;
      f_x   <= '0;
      f_y   <= '0;
      f_z   <= '0;
      f_gx  <= '0;
      f_gy  <= '0;
      f_gz  <= '0;
      qv_q  <= 1'b0;
      gv_q  <= 1'b0;
      pc_q  <= '0;
      err_q <= '0;
    end else begin
      pv_q  <= word_done & hdr_ok;
      he_q  <= word_done & ~hdr_ok;
      to_q  <= to_hit;
      err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (word_done && hdr_ok) begin
        f_w  <= shreg_q[118:103];
        f_x  <= shreg_q[102:87];
        f_y  <= shreg_q[86:71];
        f_z  <= shreg_q[70:55];
        f_gx <= shreg_q[54:39];
        f_gy <= shreg_q[38:23];
        f_gz <= shreg_q[22:7];
        gv_q <= shreg_q[0];
        qv_q <= sdi;
        pc_q <= pc_q + 16'd1;
      end
    end
  end

  assign sck         = sck_q;
  assign sdo         = 1'b0;
  assign load        = (state_q == S_ACK);
  assign busy        = (state_q != S_IDLE);
  assign pkt_valid   = pv_q;
  assign hdr_err     = he_q;
  assign timeout_err = to_q;
  assign quat_w      = f_w;
  assign quat_x      = f_x;
  assign quat_y      = f_y;
  assign quat_z      = f_z;
  assign gyro_x      = f_gx;
  assign gyro_y      = f_gy;
  assign gyro_z      = f_gz;
  assign quat_valid  = qv_q;
  assign gyro_valid  = gv_q;
  assign pkt_count   = pc_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_spi_packet_master.sv
// Bench for spi_packet_master: behavioural Mode-0 slave plus a field-level reference model.
// Scenario tasks run in sequence from one initial block and check inline.
module tb_spi_packet_master;

  logic clk = 1'b0;
  logic rst, done, sdi, sck, sdo, load, busy;
  logic pkt_valid, hdr_err, timeout_err;
  logic signed [15:0] quat_w, quat_x, quat_y, quat_z;
  logic signed [15:0] gyro_x, gyro_y, gyro_z;
  logic quat_valid, gyro_valid;
  logic [15:0] pkt_count;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  spi_packet_master dut (
    .clk(clk), .rst(rst), .done(done), .sdi(sdi),
    .sck(sck), .sdo(sdo), .load(load), .busy(busy),
    .pkt_valid(pkt_valid), .hdr_err(hdr_err),
    .timeout_err(timeout_err),
    .quat_w(quat_w), .quat_x(quat_x),
    .quat_y(quat_y), .quat_z(quat_z),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .quat_valid(quat_valid), .gyro_valid(gyro_valid),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  // behavioural slave: bit 127 presented up front, next bit after each sck fall
  logic [127:0] slave_pkt = '0;
  int sck_falls = 0;
  int sck_rises = 0;
  int fall_base = 0;
  int cur_bit;
  always @(negedge sck) sck_falls = sck_falls + 1;
  always @(posedge sck) sck_rises = sck_rises + 1;
  assign cur_bit = sck_falls - fall_base;
  assign sdi = (cur_bit >= 0 && cur_bit < 128) ?
               slave_pkt[7'(127 - cur_bit)] : 1'b0;

  logic signed [15:0] o_f [7];
  always_comb begin
    o_f[0] = quat_w; o_f[1] = quat_x;
    o_f[2] = quat_y; o_f[3] = quat_z;
    o_f[4] = gyro_x; o_f[5] = gyro_y;
    o_f[6] = gyro_z;
  end

  // reference model state
  logic signed [15:0] m_f [7];
  logic m_qv, m_gv;
  logic [15:0] m_pc;
  logic [7:0] m_ec;

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m_f[i] = '0;
    m_qv = 0; m_gv = 0; m_pc = 0; m_ec = 0;
  endtask

  task automatic model_pkt(input logic [7:0] hdr,
                           input logic [6:0][15:0] f,
                           input logic [7:0] flags);
    if (hdr == 8'hAA) begin
      for (int i = 0; i < 7; i++) m_f[i] = f[i];
      m_qv = flags[0];
      m_gv = flags[1];
      m_pc = m_pc + 16'd1;
    end else begin
      m_ec = (m_ec == 8'hFF) ? 8'hFF : m_ec + 8'd1;
    end
  endtask

  function automatic logic [127:0] mkpkt(input logic [7:0] hdr,
                                          input logic [6:0][15:0] f,
                                          input logic [7:0] flags);
    return {hdr, f[0], f[1], f[2], f[3], f[4], f[5], f[6], flags};
  endfunction

  task automatic rand_fields(output logic [6:0][15:0] f,
                             output logic [7:0] flags);
    for (int i = 0; i < 7; i++) f[i] = 16'($urandom);
    flags = 8'($urandom);
  endtask

  // per-transfer observations
  int r_pv, r_hdr, r_to, r_load, r_rise, r_first, r_to_dly, r_gap;
  logic signed [15:0] c_f [7];
  logic c_qv, c_gv;

  // mode 0: drop done on load; 1: done stuck high;
  // 2: drop done when load ends and reassert one cycle later
  task automatic do_packet(input logic [127:0] pkt, input int mode);
    int rise_base, wait_entry, drop_cyc;
    bit seen_busy, seen_load, fin;
    slave_pkt = pkt;
    fall_base = sck_falls;
    rise_base = sck_rises;
    done = 1'b1;
    r_pv = 0; r_hdr = 0; r_to = 0; r_load = 0;
    r_first = -1; r_to_dly = -1; r_gap = -1;
    wait_entry = -1; drop_cyc = -1;
    seen_busy = 0; seen_load = 0; fin = 0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      if (r_first < 0 && sck_rises != rise_base) r_first = cyc;
      if (pkt_valid || hdr_err) begin
        c_f = o_f; c_qv = quat_valid; c_gv = gyro_valid;
      end
      r_pv  += int'(pkt_valid);
      r_hdr += int'(hdr_err);
      if (timeout_err) begin
        r_to++;
        r_to_dly = cyc - wait_entry;
      end
      if (load) begin
        r_load++;
        seen_load = 1;
        if (mode == 0) done = 1'b0;
      end else if (seen_load && wait_entry < 0) begin
        wait_entry = cyc;
        if (mode == 2) begin
          done = 1'b0;
          drop_cyc = cyc;
        end
      end
      if (mode == 2 && drop_cyc > 0 && cyc == drop_cyc + 1)
        done = 1'b1;
      if (busy) seen_busy = 1;
      else if (seen_busy) begin
        fin = 1;
        break;
      end
    end
    r_rise = sck_rises - rise_base;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL transfer_budget got busy=%0b exp idle", busy);
    end
    if (mode == 2 && fin) begin
      for (int g = 1; g <= 10; g++) begin
        @(negedge clk);
        if (busy) begin
          r_gap = g;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sck, sdo, load, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0000", {sck, sdo, load, busy});
    end
    checks++;
    if ({pkt_valid, hdr_err, timeout_err} !== 3'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b exp 000",
               {pkt_valid, hdr_err, timeout_err});
    end
    checks++;
    if (pkt_count !== 16'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts got %0d/%0d exp 0/0",
               pkt_count, err_count);
    end
    checks++;
    if ({quat_w, gyro_z, quat_valid, gyro_valid} !== 34'd0) begin
      errors++;
      $display("FAIL reset_fields got %h exp 0",
               {quat_w, gyro_z, quat_valid, gyro_valid});
    end
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_packet();
    logic [6:0][15:0] f;
    f[0] = 16'h1234; f[1] = 16'hFEDC; f[2] = 16'h0001;
    f[3] = 16'h8000; f[4] = 16'h7FFF; f[5] = 16'hFFFF;
    f[6] = 16'h00A5;
    do_packet(mkpkt(8'hAA, f, 8'h03), 0);
    model_pkt(8'hAA, f, 8'h03);
    checks++;
    if (r_rise !== 128) begin
      errors++; $display("FAIL good_rises got %0d exp 128", r_rise);
    end
    checks++;
    if (r_pv !== 1 || r_hdr !== 0) begin
      errors++;
      $display("FAIL good_pulse got pv=%0d he=%0d exp 1/0", r_pv, r_hdr);
    end
    checks++;
    if (r_load !== 4) begin
      errors++; $display("FAIL good_load got %0d exp 4", r_load);
    end
    checks++;
    if (r_first !== 11) begin
      errors++; $display("FAIL good_latency got %0d exp 11", r_first);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (c_f[i] !== m_f[i]) begin
        errors++;
        $display("FAIL good_field%0d got %h exp %h", i, c_f[i], m_f[i]);
      end
    end
    checks++;
    if (quat_x !== -16'sd292 || quat_z !== -16'sd32768) begin
      errors++;
      $display("FAIL good_signed got %0d/%0d exp -292/-32768",
               quat_x, quat_z);
    end
    checks++;
    if ({c_qv, c_gv} !== {m_qv, m_gv}) begin
      errors++;
      $display("FAIL good_flags got %b exp %b", {c_qv, c_gv}, {m_qv, m_gv});
    end
    checks++;
    if (pkt_count !== m_pc) begin
      errors++; $display("FAIL good_count got %0d exp %0d", pkt_count, m_pc);
    end
  endtask

  task automatic test_random_packets();
    logic [6:0][15:0] f;
    logic [7:0] fl;
    for (int n = 0; n < 3; n++) begin
      rand_fields(f, fl);
      do_packet(mkpkt(8'hAA, f, fl), 0);
      model_pkt(8'hAA, f, fl);
      checks++;
      if (r_pv !== 1) begin
        errors++; $display("FAIL rand_pv got %0d exp 1", r_pv);
      end
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (c_f[i] !== m_f[i]) begin
          errors++;
          $display("FAIL rand_field%0d got %h exp %h", i, c_f[i], m_f[i]);
        end
      end
      checks++;
      if ({quat_valid, gyro_valid, pkt_count} !== {m_qv, m_gv, m_pc}) begin
        errors++;
        $display("FAIL rand_flags_count got %h exp %h",
                 {quat_valid, gyro_valid, pkt_count}, {m_qv, m_gv, m_pc});
      end
    end
  endtask

  task automatic test_bad_header();
    logic [6:0][15:0] f;
    logic [7:0] fl;
    rand_fields(f, fl);
    do_packet(mkpkt(8'h55, f, fl), 0);
    model_pkt(8'h55, f, fl);
    checks++;
    if (r_hdr !== 1 || r_pv !== 0) begin
      errors++;
      $display("FAIL bad_pulse got he=%0d pv=%0d exp 1/0", r_hdr, r_pv);
    end
    checks++;
    if (r_load !== 4) begin
      errors++; $display("FAIL bad_load got %0d exp 4", r_load);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (o_f[i] !== m_f[i]) begin
        errors++;
        $display("FAIL bad_hold%0d got %h exp %h", i, o_f[i], m_f[i]);
      end
    end
    checks++;
    if (err_count !== m_ec || pkt_count !== m_pc) begin
      errors++;
      $display("FAIL bad_counts got %0d/%0d exp %0d/%0d",
               err_count, pkt_count, m_ec, m_pc);
    end
  endtask

  task automatic test_stuck_done();
    logic [6:0][15:0] f;
    logic [7:0] fl;
    rand_fields(f, fl);
    do_packet(mkpkt(8'hAA, f, fl), 1);
    model_pkt(8'hAA, f, fl);
    m_ec = (m_ec == 8'hFF) ? 8'hFF : m_ec + 8'd1;
    checks++;
    if (r_to !== 1 || r_to_dly !== 1024) begin
      errors++;
      $display("FAIL stuck_timeout got n=%0d dly=%0d exp 1/1024",
               r_to, r_to_dly);
    end
    checks++;
    if (err_count !== m_ec || pkt_count !== m_pc) begin
      errors++;
      $display("FAIL stuck_counts got %0d/%0d exp %0d/%0d",
               err_count, pkt_count, m_ec, m_pc);
    end
    rand_fields(f, fl);
    do_packet(mkpkt(8'hAA, f, fl), 0);
    model_pkt(8'hAA, f, fl);
    checks++;
    if (r_pv !== 1 || r_rise !== 128) begin
      errors++;
      $display("FAIL stuck_restart got pv=%0d rises=%0d exp 1/128",
               r_pv, r_rise);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (c_f[i] !== m_f[i]) begin
        errors++;
        $display("FAIL stuck_field%0d got %h exp %h", i, c_f[i], m_f[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [6:0][15:0] f;
    logic [7:0] fl;
    int pulses;
    bit hit;
    rand_fields(f, fl);
    slave_pkt = mkpkt(8'hAA, f, fl);
    fall_base = sck_falls;
    done = 1'b1;
    hit = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (cur_bit >= 60) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL midrst_reach got bit=%0d exp 60", cur_bit);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sck, load, busy} !== 3'b0) begin
      errors++;
      $display("FAIL midrst_ctl got %b exp 000", {sck, load, busy});
    end
    checks++;
    if (pkt_count !== 16'd0 || err_count !== 8'd0 || quat_w !== 16'sd0) begin
      errors++;
      $display("FAIL midrst_state got %h/%h/%h exp 0",
               pkt_count, err_count, quat_w);
    end
    done = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(pkt_valid) + int'(hdr_err) + int'(timeout_err);
      pulses += int'(load);
    end
    rst = 1'b0;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      pulses += int'(pkt_valid) + int'(hdr_err) + int'(timeout_err);
      pulses += int'(load);
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL midrst_pulses got %0d exp 0", pulses);
    end
    rand_fields(f, fl);
    do_packet(mkpkt(8'hAA, f, fl), 0);
    model_pkt(8'hAA, f, fl);
    checks++;
    if (pkt_count !== 16'd1 || r_pv !== 1) begin
      errors++;
      $display("FAIL midrst_count got %0d/%0d exp 1/1", pkt_count, r_pv);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (o_f[i] !== m_f[i]) begin
        errors++;
        $display("FAIL midrst_field%0d got %h exp %h", i, o_f[i], m_f[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0][15:0] f;
    logic [7:0] fl;
    rand_fields(f, fl);
    do_packet(mkpkt(8'hAA, f, fl), 2);
    model_pkt(8'hAA, f, fl);
    checks++;
    if (r_pv !== 1) begin
      errors++; $display("FAIL b2b_first got %0d exp 1", r_pv);
    end
    checks++;
    if (r_gap < 1 || r_gap > 3) begin
      errors++; $display("FAIL b2b_gap got %0d exp 1..3", r_gap);
    end
    rand_fields(f, fl);
    do_packet(mkpkt(8'hAA, f, fl), 0);
    model_pkt(8'hAA, f, fl);
    checks++;
    if (r_pv !== 1 || pkt_count !== m_pc) begin
      errors++;
      $display("FAIL b2b_second got pv=%0d cnt=%0d exp 1/%0d",
               r_pv, pkt_count, m_pc);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (c_f[i] !== m_f[i]) begin
        errors++;
        $display("FAIL b2b_field%0d got %h exp %h", i, c_f[i], m_f[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [6:0][15:0] f;
    logic [7:0] fl;
    @(negedge clk);
    force dut.err_q = 8'hFD;
    @(negedge clk);
    release dut.err_q;
    @(negedge clk);
    m_ec = 8'hFD;
    checks++;
    if (err_count !== m_ec) begin
      errors++; $display("FAIL sat_preset got %h exp %h", err_count, m_ec);
    end
    for (int n = 0; n < 3; n++) begin
      rand_fields(f, fl);
      do_packet(mkpkt(8'h55, f, fl), 0);
      model_pkt(8'h55, f, fl);
      checks++;
      if (err_count !== m_ec || r_hdr !== 1) begin
        errors++;
        $display("FAIL sat_count%0d got %h/%0d exp %h/1",
                 n, err_count, r_hdr, m_ec);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    done = 1'b0;
    model_reset();
    test_reset();
    test_good_packet();
    test_random_packets();
    test_bad_header();
    test_stuck_done();
    test_mid_reset();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
